// File: rtl/qed_dup_queue.sv
// QED duplicate queue: issues original data instructions, buffers them, and
// replays them as register/memory-remapped duplicates for the SQED check.
module qed_dup_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   ifu_qed_instruction,
    input  logic          ena,
    input  logic          exec_dup,
    output logic          in_ready,
    output logic [31:0]   qed_ifu_instruction,
    output logic          vld_out,
    output logic          is_dup,
    output logic [CW-1:0] orig_cnt,
    output logic [CW-1:0] dup_cnt,
    output logic          qed_ready
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [31:0]   RESET_INSN = 32'h0000_007F;
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CW_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CW_MAX     = {CW{1'b1}};

    function automatic logic is_enq(input logic [31:0] insn);
        logic r;
        case (insn[6:0])
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI: r = 1'b1;
            default:                                           r = 1'b0;
        endcase
        return r;
    endfunction

    // Registers are constrained below x16, so adding 16 is just setting bit 4.
    function automatic logic [31:0] dup_xform(input logic [31:0] insn);
        logic [31:0] r;
        logic        use_rd;
        logic        use_rs1;
        logic        use_rs2;
        logic        use_mem;
        r = insn;
        case (insn[6:0])
            OPC_OP:     {use_rd, use_rs1, use_rs2, use_mem} = 4'b1110;
            OPC_OP_IMM: {use_rd, use_rs1, use_rs2, use_mem} = 4'b1100;
            OPC_LOAD:   {use_rd, use_rs1, use_rs2, use_mem} = 4'b1101;
            OPC_STORE:  {use_rd, use_rs1, use_rs2, use_mem} = 4'b0111;
            OPC_LUI:    {use_rd, use_rs1, use_rs2, use_mem} = 4'b1000;
            default:    {use_rd, use_rs1, use_rs2, use_mem} = 4'b0000;
        endcase
        if (use_rd && (insn[11:7] != 5'd0)) begin
            r[11] = 1'b1;
        end
        if (use_rs1 && (insn[19:15] != 5'd0)) begin
            r[19] = 1'b1;
        end
        if (use_rs2 && (insn[24:20] != 5'd0)) begin
            r[24] = 1'b1;
        end
        if (use_mem) begin
            r[26] = 1'b1;
        end
        return r;
    endfunction

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic          empty_s;
    logic          full_s;
    logic          dup_sel_s;
    logic          push_s;
    logic          pop_s;
    logic [AW:0]   count_nxt_s;
    logic [CW-1:0] orig_nxt_s;
    logic [CW-1:0] dup_nxt_s;
    logic [31:0]   head_s;

    // Mode select, queue occupancy and saturating counter next-state.
    always_comb begin
        empty_s     = (count_r == CNT_ZERO);
        full_s      = (count_r == CNT_FULL);
        dup_sel_s   = ena && !empty_s && (exec_dup || full_s);
        pop_s       = dup_sel_s;
        push_s      = ena && !dup_sel_s && is_enq(ifu_qed_instruction);
        head_s      = mem_r[rd_ptr_r];
        count_nxt_s = count_r;
        orig_nxt_s  = orig_cnt;
        dup_nxt_s   = dup_cnt;
        if (push_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
        if (push_s && (orig_cnt != CW_MAX)) begin
            orig_nxt_s = orig_cnt + CW_ONE;
        end else begin
            orig_nxt_s = orig_cnt;
        end
        if (pop_s && (dup_cnt != CW_MAX)) begin
            dup_nxt_s = dup_cnt + CW_ONE;
        end else begin
            dup_nxt_s = dup_cnt;
        end
    end

    assign in_ready = !(full_s || (exec_dup && !empty_s));

    // Queue storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= ifu_qed_instruction;
        end
    end

    // Pointers, occupancy and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            orig_cnt <= CW_ZERO;
            dup_cnt  <= CW_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r  <= count_nxt_s;
            orig_cnt <= orig_nxt_s;
            dup_cnt  <= dup_nxt_s;
        end
    end

    // Issue stage toward the core and the check-point flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qed_ifu_instruction <= RESET_INSN;
            vld_out             <= 1'b0;
            is_dup              <= 1'b0;
            qed_ready           <= 1'b0;
        end else begin
            if (ena) begin
                qed_ifu_instruction <= dup_sel_s ? dup_xform(head_s) : ifu_qed_instruction;
                vld_out             <= 1'b1;
                is_dup              <= dup_sel_s;
            end else begin
                vld_out             <= 1'b0;
            end
            qed_ready <= (orig_nxt_s == dup_nxt_s) && (orig_nxt_s != CW_ZERO)
                         && (count_nxt_s == CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_qed_dup_queue.sv
// Directed self-checking bench for qed_dup_queue with hand-computed expectations.
module tb_qed_dup_queue;

    localparam logic [31:0] ADD_I   = 32'h0020_81B3;
    localparam logic [31:0] ADD_D   = 32'h0128_89B3;
    localparam logic [31:0] LW_I    = 32'h0080_2283;
    localparam logic [31:0] LW_D    = 32'h0480_2A83;
    localparam logic [31:0] SW_I    = 32'h0040_2223;
    localparam logic [31:0] SW_D    = 32'h0540_2223;
    localparam logic [31:0] BEQ_I   = 32'h0020_8463;
    localparam logic [31:0] NOP_I   = 32'h0000_007F;
    localparam logic [31:0] RS_MASK = 32'h0008_0800;

    logic        clk;
    logic        resetn;
    logic [31:0] ifu_qed_instruction;
    logic        ena;
    logic        exec_dup;
    logic        in_ready;
    logic [31:0] qed_ifu_instruction;
    logic        vld_out;
    logic        is_dup;
    logic [15:0] orig_cnt;
    logic [15:0] dup_cnt;
    logic        qed_ready;

    int n_cmp = 0;
    int n_err = 0;

    qed_dup_queue #(.DEPTH(8), .CW(16)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .ifu_qed_instruction (ifu_qed_instruction),
        .ena                 (ena),
        .exec_dup            (exec_dup),
        .in_ready            (in_ready),
        .qed_ifu_instruction (qed_ifu_instruction),
        .vld_out             (vld_out),
        .is_dup              (is_dup),
        .orig_cnt            (orig_cnt),
        .dup_cnt             (dup_cnt),
        .qed_ready           (qed_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] insn, input logic en, input logic ed);
        ifu_qed_instruction = insn;
        ena                 = en;
        exec_dup            = ed;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADDI xk, xk, k
    function automatic logic [31:0] addi(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return (kk << 20) | (kk << 15) | (kk << 7) | 32'h0000_0013;
    endfunction

    initial begin
        resetn = 1'b0;
        drive(32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_insn", qed_ifu_instruction, NOP_I);
        check("rst_vld", {31'd0, vld_out}, 32'd0);
        check("rst_isdup", {31'd0, is_dup}, 32'd0);
        check("rst_orig", {16'd0, orig_cnt}, 32'd0);
        check("rst_dup", {16'd0, dup_cnt}, 32'd0);
        check("rst_qrdy", {31'd0, qed_ready}, 32'd0);
        check("rst_inrdy", {31'd0, in_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        // ADD original, hold, then duplicate
        drive(ADD_I, 1'b1, 1'b0);
        #1 check("add_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        check("add_out", qed_ifu_instruction, ADD_I);
        check("add_vld", {31'd0, vld_out}, 32'd1);
        check("add_isdup", {31'd0, is_dup}, 32'd0);
        check("add_orig", {16'd0, orig_cnt}, 32'd1);
        check("add_qrdy", {31'd0, qed_ready}, 32'd0);
        drive(ADD_I, 1'b0, 1'b1);
        tick();
        check("hold_vld", {31'd0, vld_out}, 32'd0);
        check("hold_out", qed_ifu_instruction, ADD_I);
        check("hold_orig", {16'd0, orig_cnt}, 32'd1);
        check("hold_dup", {16'd0, dup_cnt}, 32'd0);
        drive(ADD_I, 1'b1, 1'b1);
        #1 check("addd_inrdy", {31'd0, in_ready}, 32'd0);
        tick();
        check("addd_out", qed_ifu_instruction, ADD_D);
        check("addd_isdup", {31'd0, is_dup}, 32'd1);
        check("addd_dup", {16'd0, dup_cnt}, 32'd1);
        check("addd_qrdy", {31'd0, qed_ready}, 32'd1);

        // LW and SW duplicates move into the upper memory half
        drive(LW_I, 1'b1, 1'b0);
        tick();
        check("lw_out", qed_ifu_instruction, LW_I);
        check("lw_qrdy", {31'd0, qed_ready}, 32'd0);
        drive(LW_I, 1'b1, 1'b1);
        tick();
        check("lwd_out", qed_ifu_instruction, LW_D);
        check("lwd_dup", {16'd0, dup_cnt}, 32'd2);
        drive(SW_I, 1'b1, 1'b0);
        tick();
        check("sw_out", qed_ifu_instruction, SW_I);
        drive(SW_I, 1'b1, 1'b1);
        tick();
        check("swd_out", qed_ifu_instruction, SW_D);
        check("swd_orig", {16'd0, orig_cnt}, 32'd3);
        check("swd_qrdy", {31'd0, qed_ready}, 32'd1);

        // Fill the queue (pointers start at 3, so they wrap)
        for (int k = 1; k <= 8; k++) begin
            drive(addi(k), 1'b1, 1'b0);
            tick();
            check("fill_out", qed_ifu_instruction, addi(k));
            check("fill_orig", {16'd0, orig_cnt}, 32'(3 + k));
        end
        drive(addi(9), 1'b1, 1'b0);
        #1 check("full_inrdy", {31'd0, in_ready}, 32'd0);
        tick();
        check("force_out", qed_ifu_instruction, addi(1) | RS_MASK);
        check("force_isdup", {31'd0, is_dup}, 32'd1);
        check("force_dup", {16'd0, dup_cnt}, 32'd4);
        check("force_orig", {16'd0, orig_cnt}, 32'd11);
        for (int k = 2; k <= 8; k++) begin
            drive(addi(9), 1'b1, 1'b1);
            tick();
            check("drain_out", qed_ifu_instruction, addi(k) | RS_MASK);
            check("drain_dup", {16'd0, dup_cnt}, 32'(3 + k));
        end
        check("drain_qrdy", {31'd0, qed_ready}, 32'd1);
        check("drain_inrdy", {31'd0, in_ready}, 32'd1);

        // Non-enqueueable opcodes on an empty queue after reset
        resetn = 1'b0;
        #2 resetn = 1'b1;
        drive(BEQ_I, 1'b1, 1'b1);
        #1 check("beq_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        check("beq_out", qed_ifu_instruction, BEQ_I);
        check("beq_isdup", {31'd0, is_dup}, 32'd0);
        check("beq_orig", {16'd0, orig_cnt}, 32'd0);
        drive(NOP_I, 1'b1, 1'b1);
        tick();
        check("nop_out", qed_ifu_instruction, NOP_I);
        check("nop_vld", {31'd0, vld_out}, 32'd1);
        check("nop_orig", {16'd0, orig_cnt}, 32'd0);
        check("nop_dup", {16'd0, dup_cnt}, 32'd0);
        check("nop_qrdy", {31'd0, qed_ready}, 32'd0);

        // Mid-cycle reset with three entries queued
        for (int k = 0; k < 3; k++) begin
            drive(ADD_I, 1'b1, 1'b0);
            tick();
        end
        check("pre_orig", {16'd0, orig_cnt}, 32'd3);
        #3 resetn = 1'b0;
        #1;
        check("ar_insn", qed_ifu_instruction, NOP_I);
        check("ar_vld", {31'd0, vld_out}, 32'd0);
        check("ar_orig", {16'd0, orig_cnt}, 32'd0);
        check("ar_inrdy", {31'd0, in_ready}, 32'd1);
        #2 resetn = 1'b1;
        drive(LW_I, 1'b1, 1'b1);
        tick();
        check("post_out", qed_ifu_instruction, LW_I);
        check("post_isdup", {31'd0, is_dup}, 32'd0);
        check("post_orig", {16'd0, orig_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
